// File: rtl/sd8_hex_display_if.sv
// Bus bundle for sd8_hex_display: conversion request (S, OF, Start)
// from the adder/subtractor side, status and 7-segment outputs back.
interface sd8_hex_display_if;
  logic [7:0] S;
  logic       OF;
  logic       Start;
  logic       Busy;
  logic       Done;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;

  // Producer side: drives the value to display, observes the segments.
  modport master (
    output S, OF, Start,
    input  Busy, Done, HEX0, HEX1, HEX2, HEX3
  );

  // Display stage side.
  modport slave (
    input  S, OF, Start,
    output Busy, Done, HEX0, HEX1, HEX2, HEX3
  );
endinterface

// File: rtl/sd8_hex_display.sv
// sd8_hex_display: captures a signed 8-bit sum and its overflow flag,
// converts |S| to three BCD digits with a bit-serial double-dabble engine
// (one bit per cycle), and drives four active-low 7-segment digits
// {g,f,e,d,c,b,a}: HEX3 sign/overflow, HEX2 hundreds, HEX1 tens, HEX0 ones.
// Optional build macro SD8_HEX_DISPLAY_LZB_EN enables leading-zero blanking
// of HEX2/HEX1; without it every digit shows its value.
module sd8_hex_display (
  input  logic                 Clk,
  input  logic                 Resetn,
  sd8_hex_display_if.slave     bus
);

  // Segment codes, active low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

`ifdef SD8_HEX_DISPLAY_LZB_EN
  localparam logic [6:0] HEX_HI_RST = SEG_BLANK;
`else
  localparam logic [6:0] HEX_HI_RST = SEG_ZERO;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [19:0] sr_q,    sr_d;
  logic        neg_q,   neg_d;
  logic        of_q,    of_d;
  logic        done_q,  done_d;
  logic [6:0]  hex0_q,  hex0_d;
  logic [6:0]  hex1_q,  hex1_d;
  logic [6:0]  hex2_q,  hex2_d;
  logic [6:0]  hex3_q,  hex3_d;

  // Magnitude of the incoming value; 0x80 maps to 128, which fits unsigned.
  logic [7:0]  mag;
  // Shift register after the per-nibble +3 correction, before the shift.
  logic [19:0] sr_adj;
  // BCD digits once all eight bits have been shifted in.
  logic [3:0]  bcd_h, bcd_t, bcd_o;

  // Decimal digit to segment pattern; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: a digit of 5 or more would carry past 9
  // after doubling, so pre-add 3 to make it carry into the next nibble.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Operand conditioning and BCD correction of the current register.
  always_comb begin
    mag    = bus.S[7] ? (~bus.S + 8'd1) : bus.S;
    sr_adj = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8]), sr_q[7:0]};
    bcd_h  = sr_q[19:16];
    bcd_t  = sr_q[15:12];
    bcd_o  = sr_q[11:8];
  end

  // Next-state and datapath control for IDLE -> SHIFT(x8) -> DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    neg_d   = neg_q;
    of_d    = of_q;
    done_d  = 1'b0;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    hex2_d  = hex2_q;
    hex3_d  = hex3_q;

    case (state_q)
      IDLE: begin
        // Start is only honoured here; requests during a conversion drop.
        if (bus.Start) begin
          neg_d   = bus.S[7];
          of_d    = bus.OF;
          sr_d    = {12'd0, mag};
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sr_d  = {sr_adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end

      DONE: begin
        hex0_d = seg7(bcd_o);
        hex1_d = seg7(bcd_t);
        hex2_d = seg7(bcd_h);
`ifdef SD8_HEX_DISPLAY_LZB_EN
        if (bcd_h == 4'd0) begin
          hex2_d = SEG_BLANK;
          if (bcd_t == 4'd0) hex1_d = SEG_BLANK;
        end
`endif
        // Overflow wins over sign; digits still show |S| either way.
        if (of_q)       hex3_d = SEG_E;
        else if (neg_q) hex3_d = SEG_MINUS;
        else            hex3_d = SEG_BLANK;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, engine and display registers; reset discards any partial work.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sr_q    <= 20'd0;
      neg_q   <= 1'b0;
      of_q    <= 1'b0;
      done_q  <= 1'b0;
      hex0_q  <= SEG_ZERO;
      hex1_q  <= HEX_HI_RST;
      hex2_q  <= HEX_HI_RST;
      hex3_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      neg_q   <= neg_d;
      of_q    <= of_d;
      done_q  <= done_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
      hex3_q  <= hex3_d;
    end
  end

  // Outputs come straight from registers (Busy decodes the state register).
  assign bus.Busy = (state_q != IDLE);
  assign bus.Done = done_q;
  assign bus.HEX0 = hex0_q;
  assign bus.HEX1 = hex1_q;
  assign bus.HEX2 = hex2_q;
  assign bus.HEX3 = hex3_q;

endmodule

// File: tb/tb_sd8_hex_display.sv
// Bench for sd8_hex_display: directed vector table, randomized values
// against an arithmetic decimal model, and multi-cycle corner sequences
// (held Start, reset mid-conversion). Honours SD8_HEX_DISPLAY_LZB_EN.
module tb_sd8_hex_display;

  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  sd8_hex_display_if bus ();

  sd8_hex_display dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] ECODE = 7'b0000110;
  logic [6:0] seg_tab [10];

  typedef struct {
    logic [7:0] s;
    logic       of;
    int         h, t, o;
    int         sg;   // 0 blank, 1 minus, 2 E
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected {HEX3,HEX2,HEX1,HEX0} for digits and sign code.
  function automatic logic [27:0] exp_disp(input int h, input int t, input int o, input int sg);
    logic [6:0] e3, e2, e1, e0;
    e2 = seg_tab[h];
    e1 = seg_tab[t];
    e0 = seg_tab[o];
`ifdef SD8_HEX_DISPLAY_LZB_EN
    if (h == 0) e2 = BLANK;
    if (h == 0 && t == 0) e1 = BLANK;
`endif
    e3 = (sg == 2) ? ECODE : (sg == 1) ? MINUS : BLANK;
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [27:0] act_disp();
    return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  function automatic logic [27:0] reset_disp();
`ifdef SD8_HEX_DISPLAY_LZB_EN
    return {BLANK, BLANK, BLANK, 7'b1000000};
`else
    return {BLANK, 7'b1000000, 7'b1000000, 7'b1000000};
`endif
  endfunction

  // One conversion: Start for one edge, then wait (bounded) for Done.
  // S/OF are scrambled after capture to show they are not re-sampled.
  task automatic convert(input logic [7:0] s, input logic of, output int lat, output logic busy1);
    @(negedge Clk);
    bus.S = s; bus.OF = of; bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    bus.S = 8'($urandom);
    bus.OF = 1'($urandom);
    lat = -1; busy1 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge Clk);
      #1;
      if (i == 1) busy1 = bus.Busy;
      if (bus.Done) begin lat = i; break; end
    end
  endtask

  initial begin
    int lat, done_cnt, d1, d2;
    logic busy1;
    logic [27:0] snap;

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    vecs[0] = '{8'h7B, 1'b0, 1, 2, 3, 0};
    vecs[1] = '{8'h80, 1'b0, 1, 2, 8, 1};
    vecs[2] = '{8'hFF, 1'b0, 0, 0, 1, 1};
    vecs[3] = '{8'h05, 1'b1, 0, 0, 5, 2};
    vecs[4] = '{8'h00, 1'b0, 0, 0, 0, 0};
    vecs[5] = '{8'h7F, 1'b0, 1, 2, 7, 0};
    vecs[6] = '{8'h81, 1'b1, 1, 2, 7, 2};
    vecs[7] = '{8'hF6, 1'b0, 0, 1, 0, 1};

    bus.S = 8'h00; bus.OF = 1'b0; bus.Start = 1'b0;

    // Reset and idle.
    Resetn = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Resetn = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_done", 32'(bus.Done), 32'd0);
    chk("reset_hex", 32'(act_disp()), 32'(reset_disp()));

    // Directed vector table.
    for (int k = 0; k < 8; k++) begin
      convert(vecs[k].s, vecs[k].of, lat, busy1);
      chk($sformatf("vec%0d_latency", k), 32'(lat), 32'd9);
      chk($sformatf("vec%0d_busy", k), 32'(busy1), 32'd1);
      chk($sformatf("vec%0d_hex", k), 32'(act_disp()),
          32'(exp_disp(vecs[k].h, vecs[k].t, vecs[k].o, vecs[k].sg)));
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_done_pulse", k), 32'(bus.Done), 32'd0);
    end

    // Randomized values against a decimal model.
    for (int k = 0; k < 40; k++) begin
      logic [7:0] s;
      logic of;
      int v, m, sg;
      s  = 8'($urandom);
      of = 1'($urandom);
      v  = (s >= 8'd128) ? int'(s) - 256 : int'(s);
      m  = (v < 0) ? -v : v;
      sg = of ? 2 : (v < 0) ? 1 : 0;
      convert(s, of, lat, busy1);
      chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'd9);
      chk($sformatf("rnd%0d_hex_s%02h", k, s), 32'(act_disp()),
          32'(exp_disp(m / 100, (m / 10) % 10, m % 10, sg)));
    end

    // Start held for 20 edges: conversions complete at edges 9 and 19 only.
    @(negedge Clk);
    bus.S = 8'h0A; bus.OF = 1'b0; bus.Start = 1'b1;
    done_cnt = 0; d1 = -1; d2 = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge Clk);
      #1;
      if (e == 3) bus.S = 8'h14;
      if (bus.Done) begin
        done_cnt++;
        if (d1 < 0) d1 = e; else d2 = e;
        if (e == 9)  chk("held_first_hex", 32'(act_disp()), 32'(exp_disp(0, 1, 0, 0)));
        if (e == 19) chk("held_second_hex", 32'(act_disp()), 32'(exp_disp(0, 2, 0, 0)));
      end
    end
    bus.Start = 1'b0;
    chk("held_done_count", 32'(done_cnt), 32'd2);
    chk("held_done_edge1", 32'(d1), 32'd9);
    chk("held_done_edge2", 32'(d2), 32'd19);

    // Reset in the middle of a conversion of 0x63 (99).
    @(negedge Clk);
    bus.S = 8'h63; bus.OF = 1'b0; bus.Start = 1'b1;
    @(posedge Clk);            // edge 0
    #1 bus.Start = 1'b0;
    repeat (4) @(posedge Clk); // edge 4
    #1 Resetn = 1'b0;
    #1;
    chk("midreset_hex", 32'(act_disp()), 32'(reset_disp()));
    chk("midreset_busy", 32'(bus.Busy), 32'd0);
    chk("midreset_done", 32'(bus.Done), 32'd0);
    @(negedge Clk);            // between edges 5 and 6 after next loop
    @(negedge Clk) Resetn = 1'b1;
    done_cnt = 0;
    snap = act_disp();
    for (int e = 0; e < 15; e++) begin
      @(posedge Clk);
      #1;
      if (bus.Done) done_cnt++;
      if (act_disp() != reset_disp()) snap = act_disp();
    end
    chk("midreset_no_done", 32'(done_cnt), 32'd0);
    chk("midreset_hold", 32'(snap), 32'(reset_disp()));

    // A fresh Start after reset shows 99.
    convert(8'h63, 1'b0, lat, busy1);
    chk("post_reset_latency", 32'(lat), 32'd9);
    chk("post_reset_hex", 32'(act_disp()), 32'(exp_disp(0, 9, 9, 0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
